// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational N-bit multiplier among R requesters.
// A grant latches operands, the next cycle registers the product, and the result is held until accepted.
module mult_arbiter_mul #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_p,
  output logic         o_v
);
  logic [2*N-1:0] w_full;

  assign w_full = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
  assign o_p    = w_full[N-1:0];
  assign o_v    = |w_full[2*N-1:N];
endmodule

module mult_arbiter #(
  parameter int N  = 4,
  parameter int R  = 2,
  parameter int IW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [IW-1:0]  resp_id,
  output logic [N-1:0]   resp_p,
  output logic           resp_v
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_op_a, r_op_b, r_p;
  logic [IW-1:0]  r_own, r_ptr, r_id;
  logic           r_v;

  logic           w_found;
  logic [IW-1:0]  w_win;
  logic [N-1:0]   w_a, w_b, w_mp;
  logic           w_mv;
  logic           w_grant;
  int             w_idx;

  // First valid requester at or above ptr, wrapping at R-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_a     = '0;
    w_b     = '0;
    w_idx   = 0;
    for (int k = 0; k < R; k++) begin
      w_idx = (int'(r_ptr) + k) % R;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
        w_a     = req_a[w_idx*N +: N];
        w_b     = req_b[w_idx*N +: N];
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && w_found && !rst;
  assign req_ready = w_grant ? (R'(1) << w_win) : '0;

  mult_arbiter_mul #(.N(N)) u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_mp),
    .o_v (w_mv)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_HOLD;
      S_HOLD:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_own   <= '0;
      r_ptr   <= '0;
      r_p     <= '0;
      r_v     <= 1'b0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_op_a <= w_a;
        r_op_b <= w_b;
        r_own  <= w_win;
      end
      if (r_state == S_CALC) begin
        r_p  <= w_mp;
        r_v  <= w_mv;
        r_id <= r_own;
      end
      // Pointer moves past the owner only once its result is consumed.
      if (r_state == S_HOLD && resp_ready)
        r_ptr <= (r_own == IW'(R-1)) ? '0 : r_own + 1'b1;
    end
  end

  assign resp_valid = (r_state == S_HOLD);
  assign resp_p     = r_p;
  assign resp_v     = r_v;
  assign resp_id    = r_id;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (N=4, R=2): reset, products, overflow, round-robin,
// backpressure and asynchronous reset mid-operation.
module tb_mult_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_a, req_b;
  logic [1:0] req_ready;
  logic       resp_valid, resp_ready, resp_v;
  logic [0:0] resp_id;
  logic [3:0] resp_p;
  logic [1:0] g;
  int total = 0;
  int bad   = 0;

  mult_arbiter #(.N(4), .R(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_p(resp_p), .resp_v(resp_v)
  );

  always #5 clk = ~clk;

  // Present one request, drop it after the grant, and stop at the first HOLD cycle (negedge).
  task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                         output logic [1:0] gnt);
    @(negedge clk);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
    #1 gnt = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b01; req_a = 8'h00; req_b = 8'h00; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", resp_valid); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got %b want 00", req_ready); end
    total++; if ({resp_p, resp_v, resp_id} !== 6'd0) begin bad++; $display("FAIL reset_result got %h want 0", {resp_p, resp_v, resp_id}); end
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    run_one(0, 4'd3, 4'd5, g);
    total++; if (g !== 2'b01) begin bad++; $display("FAIL single_grant got %b want 01", g); end
    total++; if ({resp_valid, resp_p, resp_v, resp_id} !== {1'b1, 4'd15, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_result got %b want %b", {resp_valid, resp_p, resp_v, resp_id}, {1'b1, 4'd15, 1'b0, 1'b0}); end
    @(posedge clk);
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_idle got %b want 0", resp_valid); end
  endtask

  task automatic test_overflow();
    resp_ready = 1'b1;
    run_one(1, 4'd5, 4'd4, g);
    total++; if (g !== 2'b10) begin bad++; $display("FAIL ovf_grant got %b want 10", g); end
    total++; if ({resp_valid, resp_p, resp_v, resp_id} !== {1'b1, 4'd4, 1'b1, 1'b1}) begin
      bad++; $display("FAIL ovf_5x4 got %b want %b", {resp_valid, resp_p, resp_v, resp_id}, {1'b1, 4'd4, 1'b1, 1'b1}); end
    @(posedge clk);
    run_one(0, 4'd15, 4'd15, g);
    total++; if ({resp_valid, resp_p, resp_v, resp_id} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovf_15x15 got %b want %b", {resp_valid, resp_p, resp_v, resp_id}, {1'b1, 4'd1, 1'b1, 1'b0}); end
    @(posedge clk);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    int ph, gi;
    @(negedge clk);
    rst = 1'b1; #1 rst = 1'b0;
    resp_ready = 1'b1;
    req_a = {4'd3, 4'd2}; req_b = {4'd3, 4'd3};
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ph = c % 3; gi = (c / 3) % 2;
      exp_rdy = (ph == 0) ? ((gi == 1) ? 2'b10 : 2'b01) : 2'b00;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready c=%0d got %b want %b", c, req_ready, exp_rdy); end
      total++; if (resp_valid !== (ph == 2)) begin bad++; $display("FAIL rr_valid c=%0d got %b want %b", c, resp_valid, ph == 2); end
      if (ph == 2) begin
        total++; if ({resp_id, resp_p} !== {gi[0], ((gi == 1) ? 4'd9 : 4'd6)}) begin
          bad++; $display("FAIL rr_result c=%0d got id=%0d p=%0d want id=%0d p=%0d", c, resp_id, resp_p, gi, (gi == 1) ? 9 : 6); end
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    run_one(0, 4'd7, 4'd3, g);
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b11;
      #1;
      total++; if ({resp_valid, resp_p, resp_v, resp_id, req_ready} !== {1'b1, 4'd5, 1'b1, 1'b0, 2'b00}) begin
        bad++; $display("FAIL bp_hold i=%0d got %b want %b", i, {resp_valid, resp_p, resp_v, resp_id, req_ready}, {1'b1, 4'd5, 1'b1, 1'b0, 2'b00}); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if ({resp_valid, req_ready} !== {1'b0, 2'b10}) begin
      bad++; $display("FAIL bp_release got %b want %b", {resp_valid, req_ready}, {1'b0, 2'b10}); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 2'b01; req_a = {4'd0, 4'd3}; req_b = {4'd0, 4'd3};
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    total++; if ({resp_valid, req_ready} !== 3'b000) begin bad++; $display("FAIL rst_calc got %b want 000", {resp_valid, req_ready}); end
    rst = 1'b0;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    run_one(1, 4'd3, 4'd5, g);
    total++; if ({g, resp_valid, resp_p, resp_id} !== {2'b10, 1'b1, 4'd15, 1'b1}) begin
      bad++; $display("FAIL rst_prehold got %b want %b", {g, resp_valid, resp_p, resp_id}, {2'b10, 1'b1, 4'd15, 1'b1}); end
    rst = 1'b1;
    #1;
    total++; if ({resp_valid, resp_p, resp_v, resp_id, req_ready} !== 9'd0) begin
      bad++; $display("FAIL rst_hold got %b want 0", {resp_valid, resp_p, resp_v, resp_id, req_ready}); end
    #1 rst = 1'b0;
    req_a = {4'd3, 4'd2}; req_b = {4'd3, 4'd2};
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_ptr got %b want 01", req_ready); end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_noreplay got %b want 0", resp_valid); end
    @(posedge clk);
    @(negedge clk);
    total++; if ({resp_valid, resp_p, resp_id} !== {1'b1, 4'd4, 1'b0}) begin
      bad++; $display("FAIL rst_after got %b want %b", {resp_valid, resp_p, resp_id}, {1'b1, 4'd4, 1'b0}); end
    @(posedge clk);
  endtask

  task automatic test_zero_idle();
    resp_ready = 1'b1;
    run_one(0, 4'd0, 4'd9, g);
    total++; if ({resp_valid, resp_p, resp_v, resp_id} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL zero_result got %b want %b", {resp_valid, resp_p, resp_v, resp_id}, {1'b1, 4'd0, 1'b0, 1'b0}); end
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if ({resp_valid, resp_p, resp_v, resp_id, req_ready} !== 9'd0) begin
        bad++; $display("FAIL idle i=%0d got %b want 0", i, {resp_valid, resp_p, resp_v, resp_id, req_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_zero_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
